// File: rtl/n64_vdemux_vinfo_pkg.sv
// -----------------------------------------------------------------------------
// n64_vdemux_vinfo_pkg
//   Shared video-front-end parameters: sync bit positions inside the N64 sync
//   word and inside the demuxed pixel word, line counter width, default PAL
//   line threshold and the enum types used by the demux and lock logic.
// -----------------------------------------------------------------------------
package n64_vdemux_vinfo_pkg;

   // Sync word layout on D_i[3:0] and in the top nibble of vdata_o
   localparam int unsigned VSYNC_IDX = 3;
   localparam int unsigned CLAMP_IDX = 2;
   localparam int unsigned HSYNC_IDX = 1;
   localparam int unsigned CSYNC_IDX = 0;
   localparam int unsigned SYNC_W    = 4;

   // Line/field measurement
   localparam int unsigned LINE_W         = 10;
   localparam int unsigned PAL_THRESH_DEF = 288;

   // Bit positions of each field inside vdata_o for a given colour width
   function automatic int unsigned vdata_w(input int unsigned cw);
      return SYNC_W + 3 * cw;
   endfunction

   function automatic int unsigned vdata_sync_lsb(input int unsigned cw);
      return 3 * cw;
   endfunction

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_state_e;

   // Word position within one pixel on the N64 bus
   typedef enum logic [1:0] {
      PH_SYNC = 2'd0,
      PH_R    = 2'd1,
      PH_G    = 2'd2,
      PH_B    = 2'd3
   } phase_e;

   function automatic phase_e next_phase(input phase_e ph);
      return phase_e'(ph + 2'd1);
   endfunction

endpackage

// File: rtl/n64_vdemux_vinfo_meas.sv
// -----------------------------------------------------------------------------
// n64_vinfo_meas
//   Counts lines per field from the captured sync words and derives PAL and
//   interlace flags once per field.
//
//   n64_vclk           : N64 video clock
//   nrst               : asynchronous active-low reset
//   sync_stb_i         : a new sync word has been captured this cycle
//   sync_lk_i          : that sync word belongs to a phase-locked stream
//   locked_i           : demux currently locked (low clears the field state)
//   nhsync_i/nvsync_i  : captured nHSYNC / nVSYNC bits
//   palmode_o          : last field longer than PAL_THRESH lines
//   interlaced_o       : last two field lengths differ
//   lines_per_field_o  : line count of last complete field
// -----------------------------------------------------------------------------
module n64_vinfo_meas
   import n64_vdemux_vinfo_pkg::*;
#(
   parameter int unsigned PAL_THRESH = PAL_THRESH_DEF
) (
   input  logic              n64_vclk,
   input  logic              nrst,
   input  logic              sync_stb_i,
   input  logic              sync_lk_i,
   input  logic              locked_i,
   input  logic              nhsync_i,
   input  logic              nvsync_i,
   output logic              palmode_o,
   output logic              interlaced_o,
   output logic [LINE_W-1:0] lines_per_field_o
);

   logic              prev_h_q, prev_h_d;
   logic              prev_v_q, prev_v_d;
   logic [LINE_W-1:0] cnt_q, cnt_d;
   logic [LINE_W-1:0] lpf_q, lpf_d;
   logic              seen_vs_q, seen_vs_d;
   logic              pal_q, pal_d;
   logic              intl_q, intl_d;

   logic              h_fall;
   logic              v_fall;
   logic [LINE_W-1:0] cnt_inc;

   always_comb begin
      prev_h_d  = prev_h_q;
      prev_v_d  = prev_v_q;
      cnt_d     = cnt_q;
      lpf_d     = lpf_q;
      seen_vs_d = seen_vs_q;
      pal_d     = pal_q;
      intl_d    = intl_q;

      h_fall  = prev_h_q & ~nhsync_i;
      v_fall  = prev_v_q & ~nvsync_i;
      // Saturating increment; a vsync in the same word latches this value
      cnt_inc = (h_fall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

      // Edge history follows every captured word so the first locked word
      // is compared against real bus history rather than a reset value
      if (sync_stb_i) begin
         prev_h_d = nhsync_i;
         prev_v_d = nvsync_i;
      end

      if (!locked_i) begin
         cnt_d     = '0;
         seen_vs_d = 1'b0;
      end else if (sync_stb_i && sync_lk_i) begin
         if (v_fall) begin
            lpf_d = cnt_inc;
            cnt_d = '0;
            if (seen_vs_q) begin
               pal_d  = (cnt_inc > LINE_W'(PAL_THRESH));
               intl_d = (cnt_inc != lpf_q);
            end
            seen_vs_d = 1'b1;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge n64_vclk or negedge nrst) begin
      if (!nrst) begin
         prev_h_q  <= 1'b1;
         prev_v_q  <= 1'b1;
         cnt_q     <= '0;
         lpf_q     <= '0;
         seen_vs_q <= 1'b0;
         pal_q     <= 1'b0;
         intl_q    <= 1'b0;
      end else begin
         prev_h_q  <= prev_h_d;
         prev_v_q  <= prev_v_d;
         cnt_q     <= cnt_d;
         lpf_q     <= lpf_d;
         seen_vs_q <= seen_vs_d;
         pal_q     <= pal_d;
         intl_q    <= intl_d;
      end
   end

   assign palmode_o         = pal_q;
   assign interlaced_o      = intl_q;
   assign lines_per_field_o = lpf_q;

endmodule

// File: rtl/n64_vdemux_vinfo.sv
// -----------------------------------------------------------------------------
// n64_vdemux_vinfo
//   Demultiplexes the N64 7-bit video bus (sync, R, G, B words framed by
//   nDSYNC) into one parallel pixel word with a one-cycle valid strobe,
//   tracks phase lock on nDSYNC and reports per-field video info.
//
//   n64_vclk          : N64 video clock
//   nrst              : asynchronous active-low reset
//   nDSYNC_i          : low marks the sync word of a pixel
//   D_i               : video bus, sync word D_i[3:0] = {nV, nCLAMP, nH, nC}
//   vdata_o           : {nVSYNC, nCLAMP, nHSYNC, nCSYNC, R, G, B}
//   vdata_valid_o     : one-cycle strobe, vdata_o holds a new pixel
//   locked_o          : demux phase locked
//   palmode_o         : PAL line count detected
//   interlaced_o      : consecutive field lengths differ
//   lines_per_field_o : last complete field line count
// -----------------------------------------------------------------------------
module n64_vdemux_vinfo
   import n64_vdemux_vinfo_pkg::*;
#(
   parameter int unsigned COLOR_W    = 7,
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned PAL_THRESH = PAL_THRESH_DEF
) (
   input  logic                         n64_vclk,
   input  logic                         nrst,
   input  logic                         nDSYNC_i,
   input  logic [COLOR_W-1:0]           D_i,
   output logic [SYNC_W+3*COLOR_W-1:0]  vdata_o,
   output logic                         vdata_valid_o,
   output logic                         locked_o,
   output logic                         palmode_o,
   output logic                         interlaced_o,
   output logic [LINE_W-1:0]            lines_per_field_o
);

   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned VD_W   = vdata_w(COLOR_W);

   localparam logic [VD_W-1:0] VDATA_RST =
      {{SYNC_W{1'b1}}, {(VD_W - SYNC_W){1'b0}}};

   phase_e             phase_q, phase_d;
   lock_state_e        state_q, state_d;
   logic [GOOD_W-1:0]  good_q, good_d;
   logic [SYNC_W-1:0]  sync_q, sync_d;
   logic [COLOR_W-1:0] r_q, r_d;
   logic [COLOR_W-1:0] g_q, g_d;
   logic [VD_W-1:0]    vdata_q, vdata_d;
   logic               valid_q, valid_d;
   logic               sync_stb_q, sync_stb_d;
   logic               sync_lk_q, sync_lk_d;

   logic               dsync;
   phase_e             cur_phase;
   logic [GOOD_W-1:0]  good_nxt;
   logic               lock_err;

   always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      sync_d     = sync_q;
      r_d        = r_q;
      g_d        = g_q;
      vdata_d    = vdata_q;
      valid_d    = 1'b0;
      good_nxt   = good_q;
      lock_err   = 1'b0;

      dsync      = ~nDSYNC_i;
      // A DSYNC pulse always defines phase 0, re-aligning the counter
      cur_phase  = dsync ? PH_SYNC : phase_q;
      phase_d    = next_phase(cur_phase);

      sync_stb_d = dsync;
      sync_lk_d  = dsync && (state_q == ST_LOCKED) && (phase_q == PH_SYNC);

      if (dsync) begin
         sync_d = D_i[SYNC_W-1:0];
      end
      case (cur_phase)
         PH_R:    r_d = D_i;
         PH_G:    g_d = D_i;
         default: ;
      endcase

      unique case (state_q)
         ST_UNLOCKED: begin
            if (dsync) begin
               good_nxt = (phase_q == PH_SYNC) ? good_q + 1'b1 : GOOD_W'(1);
               good_d   = good_nxt;
               if (good_nxt == GOOD_W'(LOCK_CNT)) begin
                  state_d = ST_LOCKED;
               end
            end
         end
         ST_LOCKED: begin
            lock_err = (dsync && (phase_q != PH_SYNC)) ||
                       (!dsync && (phase_q == PH_SYNC));
            if (lock_err) begin
               // Pixel in flight is dropped simply by leaving LOCKED before
               // its B word; the re-aligning pulse counts as the first good one
               state_d = ST_UNLOCKED;
               good_d  = dsync ? GOOD_W'(1) : '0;
            end else if (cur_phase == PH_B) begin
               vdata_d = {sync_q, r_q, g_q, D_i};
               valid_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge n64_vclk or negedge nrst) begin
      if (!nrst) begin
         phase_q    <= PH_SYNC;
         state_q    <= ST_UNLOCKED;
         good_q     <= '0;
         sync_q     <= '1;
         r_q        <= '0;
         g_q        <= '0;
         vdata_q    <= VDATA_RST;
         valid_q    <= 1'b0;
         sync_stb_q <= 1'b0;
         sync_lk_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         state_q    <= state_d;
         good_q     <= good_d;
         sync_q     <= sync_d;
         r_q        <= r_d;
         g_q        <= g_d;
         vdata_q    <= vdata_d;
         valid_q    <= valid_d;
         sync_stb_q <= sync_stb_d;
         sync_lk_q  <= sync_lk_d;
      end
   end

   n64_vinfo_meas #(
      .PAL_THRESH (PAL_THRESH)
   ) u_meas (
      .n64_vclk          (n64_vclk),
      .nrst              (nrst),
      .sync_stb_i        (sync_stb_q),
      .sync_lk_i         (sync_lk_q),
      .locked_i          (state_q == ST_LOCKED),
      .nhsync_i          (sync_q[HSYNC_IDX]),
      .nvsync_i          (sync_q[VSYNC_IDX]),
      .palmode_o         (palmode_o),
      .interlaced_o      (interlaced_o),
      .lines_per_field_o (lines_per_field_o)
   );

   assign vdata_o       = vdata_q;
   assign vdata_valid_o = valid_q;
   assign locked_o      = (state_q == ST_LOCKED);

endmodule

// File: doc/n64_vdemux_vinfo.md
Name: n64_vdemux_vinfo

Overview:
- Front-end stage directly upstream of the scaler, in the n64_vclk domain.
- Demultiplexes the raw N64 7-bit video bus (one sync word plus R, G, B words per pixel, framed by nDSYNC) into one parallel pixel word with sync bits, plus a single-cycle valid strobe.
- Tracks phase lock on nDSYNC and derives per-frame video info (PAL/NTSC, interlaced) that the scaler consumes as vinfo_i.

Parameters:
- COLOR_W, 7, bits per colour channel on the N64 bus and at the output.
- LOCK_CNT, 4, consecutive correctly spaced nDSYNC pulses required to enter LOCKED.
- PAL_THRESH, 288, lines per field; a field longer than this is PAL.

Ports:
- n64_vclk  in  1  N64 video clock
- nrst  in  1  asynchronous active-low reset
- nDSYNC_i  in  1  low = current D_i word is the sync word
- D_i  in  COLOR_W  N64 video bus; sync word layout D_i[3:0] = {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
- vdata_o  out  4+3*COLOR_W  {nVSYNC, nCLAMP, nHSYNC, nCSYNC, R, G, B}
- vdata_valid_o  out  1  one-cycle strobe, vdata_o is new
- locked_o  out  1  demux phase locked
- palmode_o  out  1  1 = PAL line count detected
- interlaced_o  out  1  1 = consecutive field lengths differ
- lines_per_field_o  out  10  last complete field line count

Behaviour:
- Reset (async, nrst low):
  - vdata_o = {4'b1111, 0}; vdata_valid_o = 0; locked_o = 0; palmode_o = 0; interlaced_o = 0; lines_per_field_o = 0.
  - Phase counter = 0; state = UNLOCKED.
- Phase counter, 2 bits:
  - A cycle with nDSYNC_i low is phase 0; the counter increments each cycle and wraps 3 to 0.
  - Capture: phase 0 -> sync word; phase 1 -> R; phase 2 -> G; phase 3 -> B.
  - On the cycle after phase 3, vdata_o is updated with the full pixel and vdata_valid_o pulses high for one cycle. Latency from B sample to valid is 1 cycle. Valid strobes are spaced exactly 4 cycles.
- Lock FSM, states UNLOCKED, LOCKED:
  - UNLOCKED:
    - nDSYNC_i low when the counter predicts phase 0 increments the good count.
    - nDSYNC_i low at any other phase resets the good count to 1 and re-aligns the counter to phase 0.
    - The good count reaching LOCK_CNT moves to LOCKED; locked_o = 1 from the next cycle.
    - vdata_valid_o is held 0 and vdata_o is held in UNLOCKED.
  - LOCKED:
    - nDSYNC_i low at phase != 0, or nDSYNC_i high at phase 0, is an error. On error go to UNLOCKED, set locked_o = 0, and set the good count to 1 if nDSYNC_i is low (re-align), else 0.
    - A pixel in flight during an error is discarded; no valid strobe is issued for it.
- Line/field measurement, LOCKED only, evaluated on captured sync words:
  - An nHSYNC falling edge (previous captured 1, current 0) increments a 10-bit line counter, saturating at 1023.
  - An nVSYNC falling edge latches line counter to lines_per_field_o, then clears the counter to 0.
  - palmode_o = (latched count > PAL_THRESH).
  - interlaced_o = (latched count != previous latched count).
  - All three outputs update together, one cycle after the vsync edge word is captured.
  - The first vsync after lock only latches the count; palmode_o and interlaced_o update only from the second vsync onward.
- Simultaneous hsync and vsync falling edges in the same sync word: the count latches with the hsync increment included, then clears.
- Loss of lock clears the line counter and the first-field flag. palmode_o, interlaced_o and lines_per_field_o hold their last values.

Decomposition:
- Shared package (vparams header): sync bit index constants (VSYNC_IDX = 3, CLAMP_IDX = 2, HSYNC_IDX = 1, CSYNC_IDX = 0), output slice macros, PAL_THRESH default.
- One sub-module: n64_vinfo_meas, covering line counting and the PAL/interlace decision, fed by captured sync bits and locked.
- The demux and lock FSM stay in the top module.

Test Plan:
- Reset release, then a clean stream (nDSYNC low every 4th cycle; sync 0xF, R = 0x11, G = 0x22, B = 0x33) -> locked_o rises after the 4th good DSYNC; valid every 4 cycles, 1 cycle after B; vdata_o = {4'hF, 7'h11, 7'h22, 7'h33}.
- While locked, insert one nDSYNC low at phase 2 -> locked_o falls next cycle; no valid for the broken pixel; relock after 4 good pulses with the new alignment.
- Field lengths 263 and 262 alternating, 4 fields -> lines_per_field_o toggles 263/262; palmode_o = 0; interlaced_o = 1 from the 2nd vsync.
- Constant 313-line fields -> lines_per_field_o = 313, palmode_o = 1, interlaced_o = 0.
- Assert nrst low mid-pixel (phase 2) -> all outputs at reset values immediately; after release, relock from scratch.
- Drop nDSYNC entirely for 8 cycles while locked -> error at the first missing phase 0; locked_o = 0; vdata_valid_o stays 0 until relock.
